// File: rtl/wb_write_port_if.sv
// wb_write_port_if: ALU and multi-cycle result inputs plus the registered register-file write stream
interface wb_write_port_if;
  logic        alu_we;
  logic [4:0]  alu_wn;
  logic [31:0] alu_d;
  logic        mu_valid;
  logic        mu_ready;
  logic [4:0]  mu_wn;
  logic [31:0] mu_d;
  logic        we;
  logic [4:0]  wn;
  logic [31:0] d;
  modport master(output alu_we, alu_wn, alu_d, mu_valid, mu_wn, mu_d, input mu_ready, we, wn, d);
  modport slave(input alu_we, alu_wn, alu_d, mu_valid, mu_wn, mu_d, output mu_ready, we, wn, d);
endinterface

// File: rtl/wb_write_port.sv
// wb_write_port: merges ALU write-back (priority) with a FIFO of multi-cycle results into one write port.
// Define WB_FWD_EN to build the decode-stage forwarding lookup; otherwise the fwd_* outputs are tied 0.
module wb_write_port #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clrn,
  wb_write_port_if.slave   b,
  input  logic [4:0]       rna,
  input  logic [4:0]       rnb,
  output logic             fwd_hit_a,
  output logic             fwd_hit_b,
  output logic [31:0]      fwd_a,
  output logic [31:0]      fwd_b,
  output logic [CW-1:0]    count
);
  logic [AW-1:0] head, tail;
  logic [DEPTH-1:0] vld;
  logic [4:0] fwn [DEPTH];
  logic [31:0] fd [DEPTH];
  logic alu_acc, push, pop;
  assign alu_acc = b.alu_we && b.alu_wn != 5'd0;
  assign b.mu_ready = count < CW'(DEPTH);
  assign pop = !alu_acc && count != '0;
  assign push = b.mu_valid && b.mu_ready && b.mu_wn != 5'd0;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      vld <= '0;
      b.we <= 1'b0;
      b.wn <= 5'd0;
      b.d <= 32'd0;
    end else begin
      head <= head + AW'(pop);
      tail <= tail + AW'(push);
      count <= count + CW'(push) - CW'(pop);
      // older entries to the same register are superseded; the new push is younger and survives
      for (int i = 0; i < DEPTH; i++)
        if (alu_acc && fwn[i] == b.alu_wn) vld[i] <= 1'b0;
      if (push) vld[tail] <= 1'b1;
      b.we <= alu_acc || (pop && vld[head]);
      if (alu_acc) begin
        b.wn <= b.alu_wn;
        b.d <= b.alu_d;
      end else if (pop) begin
        b.wn <= fwn[head];
        b.d <= fd[head];
      end
    end
  always_ff @(posedge clk)
    if (push) begin
      fwn[tail] <= b.mu_wn;
      fd[tail] <= b.mu_d;
    end
`ifdef WB_FWD_EN
  logic [4:0] rn [2];
  logic [32:0] fw [2];
  logic [AW-1:0] idx;
  assign rn[0] = rna;
  assign rn[1] = rnb;
  // later assignments override earlier ones, so the walk runs from lowest to highest priority
  always_comb begin
    idx = '0;
    for (int p = 0; p < 2; p++) begin
      fw[p] = '0;
      if (rn[p] != 5'd0) begin
        if (b.we && b.wn == rn[p]) fw[p] = {1'b1, b.d};
        for (int k = 0; k < DEPTH; k++) begin
          idx = head + AW'(k);
          if (CW'(k) < count && vld[idx] && fwn[idx] == rn[p]) fw[p] = {1'b1, fd[idx]};
        end
        if (b.alu_we && b.alu_wn == rn[p]) fw[p] = {1'b1, b.alu_d};
      end
    end
  end
  assign {fwd_hit_a, fwd_a} = fw[0];
  assign {fwd_hit_b, fwd_b} = fw[1];
`else
  logic unused_rn;
  assign unused_rn = ^{rna, rnb};
  assign fwd_hit_a = 1'b0;
  assign fwd_hit_b = 1'b0;
  assign fwd_a = 32'd0;
  assign fwd_b = 32'd0;
`endif
endmodule

// File: tb/tb_wb_write_port.sv
// tb_wb_write_port: directed and random stimulus checked against a queue-based reference model
module tb_wb_write_port;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct {
    logic [4:0]  wn;
    logic [31:0] d;
    logic        v;
  } ent_t;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic [4:0] rna = 5'd0, rnb = 5'd0;
  logic fwd_hit_a, fwd_hit_b;
  logic [31:0] fwd_a, fwd_b;
  logic [CW-1:0] count;
  int total = 0;
  int bad = 0;
  ent_t q[$];
  logic mwe = 1'b0;
  logic [4:0] mwn = 5'd0;
  logic [31:0] md = 32'd0;
  wb_write_port_if bus();
  wb_write_port #(.DEPTH(DEPTH)) dut (
    .clk(clk), .clrn(clrn), .b(bus.slave), .rna(rna), .rnb(rnb),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b), .fwd_a(fwd_a), .fwd_b(fwd_b), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [32:0] mfwd(input logic [4:0] rn);
    logic [32:0] r;
    r = '0;
`ifdef WB_FWD_EN
    if (rn != 5'd0) begin
      if (mwe && mwn == rn) r = {1'b1, md};
      foreach (q[i]) if (q[i].v && q[i].wn == rn) r = {1'b1, q[i].d};
      if (bus.alu_we && bus.alu_wn == rn) r = {1'b1, bus.alu_d};
    end
`else
    if (rn == 5'd31) r = '0;
`endif
    return r;
  endfunction
  task automatic cycle(input logic awe, input logic [4:0] awn, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mvn, input logic [31:0] mvd,
                       input logic [4:0] ra, input logic [4:0] rb);
    logic rdy;
    logic [32:0] fa, fb;
    ent_t e;
    bus.alu_we = awe; bus.alu_wn = awn; bus.alu_d = ad;
    bus.mu_valid = mv; bus.mu_wn = mvn; bus.mu_d = mvd;
    rna = ra; rnb = rb;
    #1;
    rdy = q.size() < DEPTH;
    fa = mfwd(ra);
    fb = mfwd(rb);
    chk("mu_ready", bus.mu_ready, rdy);
    chk("hit_a", fwd_hit_a, fa[32]);
    chk("fwd_a", fwd_a, fa[31:0]);
    chk("hit_b", fwd_hit_b, fb[32]);
    chk("fwd_b", fwd_b, fb[31:0]);
    @(posedge clk);
    if (awe && awn != 5'd0) begin
      mwe = 1'b1; mwn = awn; md = ad;
      foreach (q[i]) if (q[i].wn == awn) q[i].v = 1'b0;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      mwe = e.v; mwn = e.wn; md = e.d;
    end else mwe = 1'b0;
    if (mv && rdy && mvn != 5'd0) q.push_back('{wn: mvn, d: mvd, v: 1'b1});
    #1;
    chk("we", bus.we, mwe);
    chk("wn", bus.wn, mwn);
    chk("d", bus.d, md);
    chk("count", count, 32'(q.size()));
  endtask
  task automatic idle(input logic [4:0] ra);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, 5'd0);
  endtask
  initial begin
    bus.alu_we = 1'b0; bus.alu_wn = 5'd0; bus.alu_d = 32'd0;
    bus.mu_valid = 1'b0; bus.mu_wn = 5'd0; bus.mu_d = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", bus.we, 0);
    chk("rst_wn", bus.wn, 0);
    chk("rst_d", bus.d, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", bus.mu_ready, 1);
    clrn = 1'b1;
    idle(5'd0);
    cycle(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    chk("alu5_we", bus.we, 1);
    chk("alu5_wn", bus.wn, 5);
    chk("alu5_d", bus.d, 32'h11);
    cycle(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    chk("alu0_we", bus.we, 0);
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 5'(10 + i), 32'h100 + 32'(i), i < 5, 5'(16 + i), 32'h200 + 32'(i), 5'd16, 5'(17 + i));
    chk("stall_count", count, 4);
    chk("stall_ready", bus.mu_ready, 0);
    for (int i = 0; i < 4; i++) begin
      idle(5'd17);
      chk("drain_wn", bus.wn, 32'(16 + i));
      chk("drain_d", bus.d, 32'h200 + 32'(i));
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA, 5'd7, 5'd0);
    cycle(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    chk("sq_d", bus.d, 32'hBB);
    idle(5'd7);
    chk("sq_bubble", bus.we, 0);
    idle(5'd7);
    cycle(1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 32'h2, 5'd3, 5'd0);
    chk("same_d1", bus.d, 32'h1);
    idle(5'd3);
    chk("same_we2", bus.we, 1);
    chk("same_d2", bus.d, 32'h2);
    cycle(1'b1, 5'd9, 32'h4, 1'b1, 5'd9, 32'h5, 5'd9, 5'd9);
    cycle(1'b1, 5'd2, 32'h7, 1'b1, 5'd9, 32'h6, 5'd9, 5'd9);
    repeat (3) idle(5'd9);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 5'd1, 32'(i), 1'b1, 5'(20 + i), 32'(i), 5'd20, 5'd21);
    #2;
    clrn = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_we", bus.we, 0);
    chk("mid_rst_ready", bus.mu_ready, 1);
    @(posedge clk);
    #1;
    q.delete();
    mwe = 1'b0; mwn = 5'd0; md = 32'd0;
    clrn = 1'b1;
    repeat (4) idle(5'd20);
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
